exu_lsu: RTL and testbench

Parametrised load/store unit for the execute stage, replacing the single-cycle, word-only store path. It accepts one memory operation at a time from execute (address = ALU result, store data = src2). It drives a handshaked memory bus with byte-lane write masks and sign/zero-extends load data. It reports completion, misalignment, illegal size and bus timeout back to the pipeline.

---
 rtl/exu_lsu_if.sv | 38 +++
 rtl/exu_lsu.sv | 167 ++++++++++++++++
 tb/tb_exu_lsu.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_lsu_if.sv
// Execute-to-LSU request/response channel and LSU-to-memory bus, bundled as one interface.
// The slave modport is the LSU; the master modport is the pipeline plus memory side.
interface exu_lsu_if #(
    parameter int unsigned ISA_WIDTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [1:0]             req_size;
    logic                   req_unsigned;
    logic [ISA_WIDTH-1:0]   req_addr;
    logic [ISA_WIDTH-1:0]   req_wdata;
    logic                   resp_valid;
    logic [ISA_WIDTH-1:0]   resp_rdata;
    logic                   resp_err;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [ISA_WIDTH-1:0]   mem_addr;
    logic                   mem_we;
    logic [ISA_WIDTH-1:0]   mem_wdata;
    logic [ISA_WIDTH/8-1:0] mem_wmask;
    logic                   mem_rsp_valid;
    logic [ISA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ready, mem_rsp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit: one operation at a time, byte-lane stores, extended loads,
// misalignment / illegal-size / bus-timeout reporting.
module exu_lsu #(
    parameter int unsigned ISA_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic        clk,
    input logic        rst,
    exu_lsu_if.slave   lsu
);
    localparam int unsigned NB   = ISA_WIDTH / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [OFFW-1:0]        off_q, off_d;
    logic [ISA_WIDTH-1:0]   maddr_q, maddr_d;
    logic [ISA_WIDTH-1:0]   mwdata_q, mwdata_d;
    logic [NB-1:0]          wmask_q, wmask_d;
    logic                   mwe_q, mwe_d;
    logic                   err_q, err_d;
    logic [ISA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [15:0]            cnt_q, cnt_d;

    logic                   size_ok;
    logic                   aligned;
    logic [2:0]             amask;
    logic [OFFW-1:0]        req_off;
    logic [NB-1:0]          lanes;
    logic [ISA_WIDTH-1:0]   rd_sh;
    logic [ISA_WIDTH-1:0]   ld_data;
    logic                   sgn;
    int                     nb;

    // Request decode: legality and store lane placement.
    always_comb begin
        amask   = 3'b000;
        case (lsu.req_size)
            2'd0:    amask = 3'b000;
            2'd1:    amask = 3'b001;
            2'd2:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
        size_ok = (lsu.req_size != 2'd3) || (ISA_WIDTH == 64);
        aligned = (lsu.req_addr[2:0] & amask) == 3'b000;
        req_off = lsu.req_addr[OFFW-1:0];
        lanes   = NB'((16'd1 << (4'd1 << lsu.req_size)) - 16'd1);
    end

    // Load extraction: shift the addressed lanes down, then extend above the access width.
    always_comb begin
        rd_sh = lsu.mem_rdata >> {off_q, 3'b000};
        sgn   = 1'b0;
        case (size_q)
            2'd0:    sgn = rd_sh[7];
            2'd1:    sgn = rd_sh[15];
            2'd2:    sgn = rd_sh[31];
            default: sgn = 1'b0;
        endcase
        nb = 32'd8 << size_q;
        ld_data = '0;
        for (int i = 0; i < int'(ISA_WIDTH); i++) begin
            ld_data[i] = (i < nb) ? rd_sh[i] : (sgn & ~uns_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        wmask_d  = wmask_q;
        mwe_d    = mwe_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (lsu.req_valid) begin
                    size_d = lsu.req_size;
                    uns_d  = lsu.req_unsigned;
                    off_d  = req_off;
                    if (!size_ok || !aligned) begin
                        // Rejected at accept: straight to response, bus untouched.
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d  = StReq;
                        mwe_d    = lsu.req_we;
                        maddr_d  = {lsu.req_addr[ISA_WIDTH-1:OFFW], {OFFW{1'b0}}};
                        mwdata_d = lsu.req_wdata << {req_off, 3'b000};
                        wmask_d  = lsu.req_we ? (lanes << req_off) : '0;
                    end
                end
            end
            StReq: begin
                cnt_d = '0;
                if (lsu.mem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lsu.mem_rsp_valid) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = mwe_q ? '0 : ld_data;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            off_q    <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            wmask_q  <= '0;
            mwe_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            wmask_q  <= wmask_d;
            mwe_q    <= mwe_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign lsu.req_ready  = (state_q == StIdle);
    assign lsu.mem_valid  = (state_q == StReq);
    assign lsu.resp_valid = (state_q == StResp);
    assign lsu.resp_err   = err_q;
    assign lsu.resp_rdata = rdata_q;
    assign lsu.mem_addr   = maddr_q;
    assign lsu.mem_we     = mwe_q;
    assign lsu.mem_wdata  = mwdata_q;
    assign lsu.mem_wmask  = wmask_q;
endmodule

// File: tb/tb_exu_lsu.sv
// Table-driven bench for exu_lsu: a 32-bit and a 64-bit instance share stimulus, and a
// scoreboard queue holds the response expected for each accepted operation.
module tb_exu_lsu;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel;
    logic        req_valid, req_we, req_unsigned, mem_ready, rsp;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata, bus_rd;

    exu_lsu_if #(.ISA_WIDTH(32)) i32 ();
    exu_lsu_if #(.ISA_WIDTH(64)) i64 ();

    exu_lsu #(.ISA_WIDTH(32), .TIMEOUT(TO)) dut32 (.clk(clk), .rst(rst), .lsu(i32));
    exu_lsu #(.ISA_WIDTH(64), .TIMEOUT(TO)) dut64 (.clk(clk), .rst(rst), .lsu(i64));

    assign i32.req_valid     = req_valid & ~sel;
    assign i32.req_we        = req_we;
    assign i32.req_size      = req_size;
    assign i32.req_unsigned  = req_unsigned;
    assign i32.req_addr      = req_addr[31:0];
    assign i32.req_wdata     = req_wdata[31:0];
    assign i32.mem_ready     = mem_ready & ~sel;
    assign i32.mem_rsp_valid = rsp & ~sel;
    assign i32.mem_rdata     = bus_rd[31:0];
    assign i64.req_valid     = req_valid & sel;
    assign i64.req_we        = req_we;
    assign i64.req_size      = req_size;
    assign i64.req_unsigned  = req_unsigned;
    assign i64.req_addr      = req_addr;
    assign i64.req_wdata     = req_wdata;
    assign i64.mem_ready     = mem_ready & sel;
    assign i64.mem_rsp_valid = rsp & sel;
    assign i64.mem_rdata     = bus_rd;

    logic        cur_ready, cur_rvalid, cur_rerr, cur_mvalid, cur_mwe;
    logic [63:0] cur_rdata, cur_maddr, cur_mwd;
    logic [7:0]  cur_mask;
    assign cur_ready  = sel ? i64.req_ready  : i32.req_ready;
    assign cur_rvalid = sel ? i64.resp_valid : i32.resp_valid;
    assign cur_rerr   = sel ? i64.resp_err   : i32.resp_err;
    assign cur_mvalid = sel ? i64.mem_valid  : i32.mem_valid;
    assign cur_mwe    = sel ? i64.mem_we     : i32.mem_we;
    assign cur_rdata  = sel ? i64.resp_rdata : {32'b0, i32.resp_rdata};
    assign cur_maddr  = sel ? i64.mem_addr   : {32'b0, i32.mem_addr};
    assign cur_mwd    = sel ? i64.mem_wdata  : {32'b0, i32.mem_wdata};
    assign cur_mask   = sel ? i64.mem_wmask  : {4'b0, i32.mem_wmask};

    // mode: 0 = normal bus response, 1 = rejected at accept, 2 = bus never responds
    typedef struct {
        bit          is64;
        bit          we;
        bit [1:0]    size;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] brd;
        int          mode;
        int          rdly;
        bit          err;
        logic [63:0] rd;
        logic [63:0] maddr;
        logic [7:0]  mask;
        logic [63:0] wd;
    } vec_t;

    typedef struct {
        bit          err;
        logic [63:0] rd;
        int          cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cur_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", cur_rvalid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("resp_err", cur_rerr, e.err);
                chk("resp_rdata", cur_rdata, e.rd);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("resp_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run(input vec_t v);
        int lat;
        sel       = v.is64;
        mem_ready = (v.rdly == 0);
        bus_rd    = v.brd;
        @(negedge clk);
        chk("req_ready_idle", cur_ready, 1'b1);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        lat = (v.mode == 1) ? 1 : ((v.mode == 2) ? 2 + TO + v.rdly : 3 + v.rdly);
        sb.push_back(exp_t'{v.err, v.rd, cyc + lat});
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", cur_ready, 1'b0);
        chk("mem_valid", cur_mvalid, v.mode != 1);
        if (v.mode != 1) begin
            chk("mem_addr", cur_maddr, v.maddr);
            chk("mem_we", cur_mwe, v.we);
            chk("mem_wmask", cur_mask, v.mask);
            if (v.we) chk("mem_wdata", cur_mwd, v.wd);
            for (int i = 0; i < v.rdly; i++) begin
                @(negedge clk);
                chk("mem_valid_hold", cur_mvalid, 1'b1);
                chk("mem_addr_hold", cur_maddr, v.maddr);
            end
            mem_ready = 1'b1;
            @(negedge clk);
            chk("mem_valid_drop", cur_mvalid, 1'b0);
            if (v.mode == 0) begin
                rsp = 1'b1;
                @(negedge clk);
                rsp = 1'b0;
            end
        end
        wait_empty();
        if (v.mode == 2) begin
            // A response arriving after the timeout must be ignored.
            @(negedge clk);
            rsp = 1'b1;
            @(negedge clk);
            rsp = 1'b0;
            chk("late_rsp_ready", cur_ready, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; bus_rd = '0;
        mem_ready = 1'b1; rsp = 1'b0;

        //                is64 we sz un addr               wdata                  brd                    md dly err rd                     maddr         mask   wd
        vecs.push_back(vec_t'{0, 1, 2, 0, 64'h80000004, 64'hDEADBEEF, 64'hFFFFFFFF, 0, 0, 0, 64'h0, 64'h80000004, 8'h0F, 64'hDEADBEEF});
        vecs.push_back(vec_t'{0, 1, 1, 0, 64'h80000002, 64'h00001234, 64'h0, 0, 0, 0, 64'h0, 64'h80000000, 8'h0C, 64'h12340000});
        vecs.push_back(vec_t'{0, 1, 0, 0, 64'h80000003, 64'h123456AB, 64'h0, 0, 0, 0, 64'h0, 64'h80000000, 8'h08, 64'hAB000000});
        vecs.push_back(vec_t'{0, 0, 0, 0, 64'h80000003, 64'h0, 64'h80FF7F01, 0, 0, 0, 64'hFFFFFF80, 64'h80000000, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 0, 1, 64'h80000003, 64'h0, 64'h80FF7F01, 0, 0, 0, 64'h00000080, 64'h80000000, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 1, 0, 64'h80000002, 64'h0, 64'h80FF7F01, 0, 0, 0, 64'hFFFF80FF, 64'h80000000, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 1, 1, 64'h80000000, 64'h0, 64'h80FF7F01, 0, 0, 0, 64'h00007F01, 64'h80000000, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 2, 0, 64'h80000000, 64'h0, 64'h80FF7F01, 0, 0, 0, 64'h80FF7F01, 64'h80000000, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 2, 0, 64'h80000002, 64'h0, 64'h80FF7F01, 1, 0, 1, 64'h0, 64'h0, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 3, 0, 64'h80000000, 64'h0, 64'h80FF7F01, 1, 0, 1, 64'h0, 64'h0, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 1, 1, 0, 64'h80000001, 64'h5555, 64'h0, 1, 0, 1, 64'h0, 64'h0, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 2, 0, 64'h80000008, 64'h0, 64'h12345678, 0, 2, 0, 64'h12345678, 64'h80000008, 8'h00, 64'h0});
        vecs.push_back(vec_t'{0, 0, 2, 0, 64'h80000010, 64'h0, 64'hFFFFFFFF, 2, 0, 1, 64'h0, 64'h80000010, 8'h00, 64'h0});
        vecs.push_back(vec_t'{1, 0, 3, 0, 64'h8, 64'h0, 64'h8000000000000001, 0, 0, 0, 64'h8000000000000001, 64'h8, 8'h00, 64'h0});
        vecs.push_back(vec_t'{1, 0, 2, 0, 64'hC, 64'h0, 64'h8000000000000000, 0, 0, 0, 64'hFFFFFFFF80000000, 64'h8, 8'h00, 64'h0});
        vecs.push_back(vec_t'{1, 0, 2, 1, 64'hC, 64'h0, 64'h8000000000000000, 0, 0, 0, 64'h0000000080000000, 64'h8, 8'h00, 64'h0});
        vecs.push_back(vec_t'{1, 1, 3, 0, 64'h10, 64'h0123456789ABCDEF, 64'h0, 0, 0, 0, 64'h0, 64'h10, 8'hFF, 64'h0123456789ABCDEF});
        vecs.push_back(vec_t'{1, 1, 2, 0, 64'h14, 64'hFFFFFFFFCAFEF00D, 64'h0, 0, 0, 0, 64'h0, 64'h10, 8'hF0, 64'hCAFEF00D00000000});
        vecs.push_back(vec_t'{1, 0, 3, 0, 64'h4, 64'h0, 64'h0, 1, 0, 1, 64'h0, 64'h0, 8'h00, 64'h0});
        vecs.push_back(vec_t'{1, 0, 0, 0, 64'hF, 64'h0, 64'h7F00000000000000, 0, 0, 0, 64'h7F, 64'h8, 8'h00, 64'h0});
        vecs.push_back(vec_t'{1, 0, 3, 1, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFE, 0, 0, 0, 64'hFFFFFFFFFFFFFFFE, 64'h0, 8'h00, 64'h0});
        vecs.push_back(vec_t'{1, 1, 2, 0, 64'h20, 64'h5, 64'h0, 2, 1, 1, 64'h0, 64'h20, 8'h0F, 64'h5});

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_req_ready", cur_ready, 1'b1);
            chk("rst_resp_valid", cur_rvalid, 1'b0);
            chk("rst_resp_err", cur_rerr, 1'b0);
            chk("rst_resp_rdata", cur_rdata, 64'h0);
            chk("rst_mem_valid", cur_mvalid, 1'b0);
            chk("rst_mem_we", cur_mwe, 1'b0);
            chk("rst_mem_wmask", cur_mask, 8'h0);
            chk("rst_mem_addr", cur_maddr, 64'h0);
            chk("rst_mem_wdata", cur_mwd, 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        // Reset while waiting on the bus: back to idle, and the stale response is ignored.
        sel = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 64'h80000020;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstwait_mem_valid", cur_mvalid, 1'b1);
        @(negedge clk);
        chk("rstwait_in_wait", cur_mvalid, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstwait_ready", cur_ready, 1'b1);
        chk("rstwait_mem_valid_off", cur_mvalid, 1'b0);
        chk("rstwait_no_resp", cur_rvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rsp = 1'b1;
        @(negedge clk);
        rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstwait_quiet_resp", cur_rvalid, 1'b0);
            chk("rstwait_quiet_ready", cur_ready, 1'b1);
            @(negedge clk);
        end
        run(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
